serial_comp_lsb: RTL and testbench
==================================

Name: serial_comp_lsb

Overview:
- Multi-cycle magnitude comparator for the processor ALU branch and set-less-than paths.
- Walks operand digit pairs (2 bits per digit) in the opposite direction to the combinational comparator cascade: LSB digit first, MSB digit last.
  - A single 2-bit digit stage per cycle, plus a running result register.
  - A more-significant digit that differs overrides any earlier (less-significant) result.
- Start/done handshake, so the control FSM can issue a compare and stall until the result is ready.
- Supports unsigned and two's-complement signed compare.

Parameters:
- WIDTH, 32, operand width in bits. Must be even and at least 2. Digit count is N = WIDTH/2.

Ports:
- clock  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request a compare; sampled only in IDLE
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; latched with start
- data_A  input  WIDTH  operand A; latched with start
- data_B  input  WIDTH  operand B; latched with start
- busy  output  1  high while a compare is in progress (RUN and DONE states)
- done  output  1  one-cycle pulse when eq/gt/lt become valid
- eq  output  1  A == B
- gt  output  1  A > B
- lt  output  1  A < B

Behaviour:
- Clock and reset: one clock, `clock`. `reset` is synchronous and active-high.
- Reset:
  - State goes to IDLE.
  - busy=0, done=0, eq=0, gt=0, lt=0.
  - Digit counter = 0, shift registers = 0, latched mode = 0.
  - Reset has priority over start and over any state, including mid-RUN; an aborted compare produces no done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - If start=1, latch data_A, data_B and signed_mode, plus sign bits sA=data_A[WIDTH-1] and sB=data_B[WIDTH-1].
  - Set running result r_eq=1, r_gt=0 and counter=0, then go to RUN.
  - Otherwise stay in IDLE.
  - eq/gt/lt keep their last values (reset value or previous result).
- RUN, one digit per cycle:
  - Digits a=A_sh[1:0], b=B_sh[1:0].
  - If a>b: r_eq=0, r_gt=1.
  - If a<b: r_eq=0, r_gt=0.
  - If a==b: r_eq and r_gt are unchanged.
  - Shift A_sh and B_sh right by 2 and increment counter.
  - When counter == N-1 (the last digit is processed this cycle), go to DONE.
- DONE, for one cycle:
  - Signed fix-up: if latched signed_mode=1 and sA != sB, final gt = sB and final eq = 0. Otherwise final eq/gt = r_eq/r_gt.
  - Register eq=final eq, gt=final gt, lt = ~final eq & ~final gt.
  - done=1 for exactly this cycle, then return to IDLE.
- Output rules:
  - eq, gt and lt are mutually exclusive after the first completed compare.
  - They hold their values until the next DONE or reset.
- Latency:
  - start sampled at edge T; RUN occupies cycles T+1..T+N; done=1 and results valid in cycle T+N+1.
  - WIDTH=32 gives a 17-cycle turnaround.
  - The next start is accepted the cycle after done (IDLE), giving back-to-back throughput of one compare every N+2 cycles.
- busy=1 in RUN and DONE; busy=0 in IDLE.
- start asserted while busy=1 is ignored: operands are not re-latched and the result is unaffected.
- Operand inputs may change freely after the start cycle.

Test Plan:
1. WIDTH=32, unsigned, A=B=0x12345678, start at T -> done pulses at T+17 only; eq=1, gt=0, lt=0; busy high T+1..T+17.
2. Unsigned, A=0x00000003, B=0x00000002 (differ only in LSB digit) -> gt=1, eq=0, lt=0.
3. Unsigned, A=0x40000000, B=0x3FFFFFFF (LSB digits favour B, MSB digit favours A) -> gt=1, lt=0 (MSB overrides).
4. Signed, A=0xFFFFFFFF (-1), B=0x00000001 -> lt=1. The same operands unsigned -> gt=1.
5. Start pulse with new operands while busy (e.g. at T+5) -> ignored; first result unchanged; no second done; a new start at T+18 is accepted and done follows at T+35.
6. Reset asserted at T+8 mid-RUN -> next cycle busy=0, eq=gt=lt=0, no done pulse; a new compare afterwards completes normally with correct result.

Source files
------------

// File: rtl/serial_comp_lsb_if.sv
// Compare request/result bundle for the serial LSB-first comparator.
// The controller drives the request side; the comparator returns status.
interface serial_comp_lsb_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] data_A;
    logic [WIDTH-1:0] data_B;
    logic             busy;
    logic             done;
    logic             eq;
    logic             gt;
    logic             lt;

    modport master (
        output start, signed_mode, data_A, data_B,
        input  busy, done, eq, gt, lt
    );

    modport slave (
        input  start, signed_mode, data_A, data_B,
        output busy, done, eq, gt, lt
    );
endinterface

// File: rtl/serial_comp_lsb.sv
// Multi-cycle magnitude comparator, one 2-bit digit per cycle, LSB first.
// Later (more significant) differing digits override earlier results.
module serial_comp_lsb #(
    parameter int WIDTH = 32
) (
    input  logic            clock,
    input  logic            reset,
    serial_comp_lsb_if.slave bus
);
    localparam int N  = WIDTH / 2;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic             sa_q, sa_d;
    logic             sb_q, sb_d;
    logic             r_eq_q, r_eq_d;
    logic             r_gt_q, r_gt_d;
    logic             eq_q, eq_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;

    logic [1:0] dig_a;
    logic [1:0] dig_b;
    logic       nx_eq;
    logic       nx_gt;
    logic       fin_eq;
    logic       fin_gt;

    // Next-state, datapath shift and result fix-up
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        r_eq_d  = r_eq_q;
        r_gt_d  = r_gt_q;
        eq_d    = eq_q;
        gt_d    = gt_q;
        lt_d    = lt_q;
        dig_a   = a_sh_q[1:0];
        dig_b   = b_sh_q[1:0];
        nx_eq   = r_eq_q;
        nx_gt   = r_gt_q;
        fin_eq  = 1'b0;
        fin_gt  = 1'b0;

        if (dig_a > dig_b) begin
            nx_eq = 1'b0;
            nx_gt = 1'b1;
        end else if (dig_a < dig_b) begin
            nx_eq = 1'b0;
            nx_gt = 1'b0;
        end

        // Operands of opposite sign: the negative one is smaller
        if (mode_q && (sa_q != sb_q)) begin
            fin_eq = 1'b0;
            fin_gt = sb_q;
        end else begin
            fin_eq = nx_eq;
            fin_gt = nx_gt;
        end

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_sh_d  = bus.data_A;
                    b_sh_d  = bus.data_B;
                    mode_d  = bus.signed_mode;
                    sa_d    = bus.data_A[WIDTH-1];
                    sb_d    = bus.data_B[WIDTH-1];
                    r_eq_d  = 1'b1;
                    r_gt_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                r_eq_d = nx_eq;
                r_gt_d = nx_gt;
                a_sh_d = a_sh_q >> 2;
                b_sh_d = b_sh_q >> 2;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    // Results land together with entry into DONE
                    eq_d    = fin_eq;
                    gt_d    = fin_gt;
                    lt_d    = ~fin_eq & ~fin_gt;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            r_eq_q  <= 1'b0;
            r_gt_q  <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            r_eq_q  <= r_eq_d;
            r_gt_q  <= r_gt_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
        end
    end

    assign bus.busy = (state_q != S_IDLE);
    assign bus.done = (state_q == S_DONE);
    assign bus.eq   = eq_q;
    assign bus.gt   = gt_q;
    assign bus.lt   = lt_q;
endmodule

// File: tb/tb_serial_comp_lsb.sv
// Directed bench for serial_comp_lsb at WIDTH=32.
// Inputs change and outputs are sampled on the falling edge.
module tb_serial_comp_lsb;
    logic clock;
    logic reset;
    int   checks;
    int   errors;

    serial_comp_lsb_if #(.WIDTH(32)) bus ();

    serial_comp_lsb #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Issue one compare from an IDLE cycle and follow it to done.
    // With inject set, a second start with swapped operands and
    // flipped mode is pulsed mid-run and must be ignored.
    task automatic run_cmp(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic        sm,
        input logic        e_eq,
        input logic        e_gt,
        input logic        e_lt,
        input string       tag,
        input bit          inject
    );
        @(negedge clock);
        chk({tag, "_idle_busy"}, bus.busy, 1'b0);
        chk({tag, "_idle_done"}, bus.done, 1'b0);
        bus.start       = 1'b1;
        bus.data_A      = a;
        bus.data_B      = b;
        bus.signed_mode = sm;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clock);
            chk($sformatf("%s_busy_c%0d", tag, k), bus.busy, 1'b1);
            chk($sformatf("%s_done_c%0d", tag, k), bus.done, k == 17);
            if (k == 1) begin
                bus.start  = 1'b0;
                bus.data_A = ~a;
                bus.data_B = ~b;
            end
            if (inject && k == 5) begin
                bus.start       = 1'b1;
                bus.data_A      = b;
                bus.data_B      = a;
                bus.signed_mode = ~sm;
            end
            if (inject && k == 6) begin
                bus.start = 1'b0;
            end
        end
        chk({tag, "_eq"}, bus.eq, e_eq);
        chk({tag, "_gt"}, bus.gt, e_gt);
        chk({tag, "_lt"}, bus.lt, e_lt);
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        reset           = 1'b1;
        bus.start       = 1'b0;
        bus.signed_mode = 1'b0;
        bus.data_A      = '0;
        bus.data_B      = '0;
        repeat (2) @(negedge clock);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_eq", bus.eq, 1'b0);
        chk("rst_gt", bus.gt, 1'b0);
        chk("rst_lt", bus.lt, 1'b0);
        reset = 1'b0;

        run_cmp(32'h12345678, 32'h12345678, 1'b0, 1, 0, 0, "eq_u", 0);
        run_cmp(32'h00000003, 32'h00000002, 1'b0, 0, 1, 0, "lsb_gt", 0);
        run_cmp(32'h40000000, 32'h3FFFFFFF, 1'b0, 0, 1, 0, "msb_ovr", 0);
        run_cmp(32'hFFFFFFFF, 32'h00000001, 1'b1, 0, 0, 1, "neg1_s", 0);
        run_cmp(32'hFFFFFFFF, 32'h00000001, 1'b0, 0, 1, 0, "neg1_u", 0);
        run_cmp(32'h00000001, 32'h00000002, 1'b0, 0, 0, 1, "lsb_lt", 0);
        run_cmp(32'h80000000, 32'h7FFFFFFF, 1'b1, 0, 0, 1, "min_s", 0);
        run_cmp(32'h80000000, 32'h7FFFFFFF, 1'b0, 0, 1, 0, "min_u", 0);
        run_cmp(32'hFFFFFFFE, 32'hFFFFFFFF, 1'b1, 0, 0, 1, "negneg", 0);
        run_cmp(32'h00000001, 32'hFFFFFFFF, 1'b1, 0, 1, 0, "pos_neg", 0);
        run_cmp(32'h00000005, 32'h00000009, 1'b0, 0, 0, 1, "busy_ign", 1);
        run_cmp(32'hABCD0000, 32'hABCC0000, 1'b0, 0, 1, 0, "b2b", 0);

        // Reset in the middle of a run aborts it without a done pulse
        @(negedge clock);
        bus.start       = 1'b1;
        bus.data_A      = 32'h00000010;
        bus.data_B      = 32'h00000020;
        bus.signed_mode = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            bus.start = 1'b0;
            chk($sformatf("abort_done_c%0d", k), bus.done, 1'b0);
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("abort_busy", bus.busy, 1'b0);
        chk("abort_done", bus.done, 1'b0);
        chk("abort_eq", bus.eq, 1'b0);
        chk("abort_gt", bus.gt, 1'b0);
        chk("abort_lt", bus.lt, 1'b0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            chk($sformatf("abort_quiet_c%0d", k), bus.done, 1'b0);
        end
        run_cmp(32'h00000010, 32'h00000020, 1'b0, 0, 0, 1, "post_rst", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
